// File: rtl/game_over_seq_if.sv
// Pixel/status bundle between the game top level and the game-over sequencer.
// The sequencer sits on the slave side; the game core drives the master side.
interface game_over_seq_if #(
  parameter int STATE_W = 4
);
  logic [10:0]        hcount_in;
  logic [9:0]         vcount_in;
  logic [STATE_W-1:0] state_in;
  logic               busy_out;
  logic               finished_out;
  logic [3:0]         phase_out;
  logic [11:0]        pixel_out;

  modport master (
    output hcount_in, vcount_in, state_in,
    input  busy_out, finished_out, phase_out, pixel_out
  );

  modport slave (
    input  hcount_in, vcount_in, state_in,
    output busy_out, finished_out, phase_out, pixel_out
  );
endinterface

// File: rtl/game_over_seq.sv
// Game-over animation: on entry to TRIGGER_STATE, flashes a box through
// NUM_PHASES colour phases of PHASE_CYCLES clocks each, then holds the last frame.
module game_over_seq #(
  parameter int                 STATE_W       = 4,
  parameter logic [STATE_W-1:0] TRIGGER_STATE = 4'hF,
  parameter int                 NUM_PHASES    = 2,
  parameter int unsigned        PHASE_CYCLES  = 65_000_000,
  parameter logic [11:0]        COLOR_EVEN    = 12'h0F0,
  parameter logic [11:0]        COLOR_ODD     = 12'hF00,
  parameter logic [11:0]        BG_COLOR      = 12'h000,
  parameter int                 BOX_H0        = 0,
  parameter int                 BOX_H1        = 1023,
  parameter int                 BOX_V0        = 0,
  parameter int                 BOX_V1        = 767
) (
  input logic            clk,
  input logic            rst,
  game_over_seq_if.slave bus
);

  localparam int                 TIMER_W    = (PHASE_CYCLES > 2) ? $clog2(PHASE_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(PHASE_CYCLES - 1);
  localparam logic [3:0]         PHASE_LAST = 4'(NUM_PHASES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state;
  logic [STATE_W-1:0]   prev_state;
  logic [TIMER_W-1:0]   timer;
  logic [3:0]           phase;
  logic                 busy;
  logic                 finished;
  logic [11:0]          pix_p1;

  logic                 at_trig;
  logic                 trig;
  logic                 in_box;
  int                   hpos;
  int                   vpos;

  function automatic logic [11:0] box_color(input logic [3:0] ph);
    return ph[0] ? COLOR_ODD : COLOR_EVEN;
  endfunction

  // Signed int positions keep the box test free of always-true unsigned compares.
  always_comb begin
    hpos    = int'(bus.hcount_in);
    vpos    = int'(bus.vcount_in);
    in_box  = (hpos >= BOX_H0) && (hpos <= BOX_H1) &&
              (vpos >= BOX_V0) && (vpos <= BOX_V1);
    at_trig = (bus.state_in == TRIGGER_STATE);
    trig    = at_trig && (prev_state != TRIGGER_STATE);
  end

  // Stage p1: control FSM and registered pixel; prev_state resets to the
  // trigger code so a held trigger state cannot start a run right after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      prev_state <= TRIGGER_STATE;
      timer      <= '0;
      phase      <= '0;
      busy       <= 1'b0;
      finished   <= 1'b0;
      pix_p1     <= BG_COLOR;
    end else begin
      prev_state <= bus.state_in;
      finished   <= 1'b0;
      pix_p1     <= ((state == RUN || state == DONE) && in_box) ? box_color(phase) : BG_COLOR;
      case (state)
        IDLE: begin
          if (trig) begin
            state <= RUN;
            busy  <= 1'b1;
            timer <= '0;
            phase <= '0;
          end
        end
        RUN: begin
          if (!at_trig) begin
            state <= IDLE;
            busy  <= 1'b0;
            timer <= '0;
            phase <= '0;
          end else if (timer == TIMER_LAST) begin
            timer <= '0;
            if (phase == PHASE_LAST) begin
              state    <= DONE;
              busy     <= 1'b0;
              finished <= 1'b1;
            end else begin
              phase <= phase + 4'd1;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DONE: begin
          if (!at_trig) begin
            state <= IDLE;
            phase <= '0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          timer <= '0;
          phase <= '0;
        end
      endcase
    end
  end

  assign bus.busy_out     = busy;
  assign bus.finished_out = finished;
  assign bus.phase_out    = phase;
  assign bus.pixel_out    = pix_p1;

endmodule

// File: tb/tb_game_over_seq.sv
// Directed bench for game_over_seq with PHASE_CYCLES=4, NUM_PHASES=3 and a
// 10..19 x 5..9 box; expected values are written out by hand per cycle.
module tb_game_over_seq;

  localparam logic [3:0] TRIG = 4'hF;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  game_over_seq_if #(.STATE_W(4)) bus ();

  game_over_seq #(
    .STATE_W(4), .TRIGGER_STATE(4'hF), .NUM_PHASES(3), .PHASE_CYCLES(4),
    .COLOR_EVEN(12'h0F0), .COLOR_ODD(12'hF00), .BG_COLOR(12'h000),
    .BOX_H0(10), .BOX_H1(19), .BOX_V0(5), .BOX_V1(9)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives state_in to TRIG before edge 0 and checks each edge up to 12.
  // abort_at >= 0 drops state_in to 3 just before that edge.
  task automatic run_seq(input int abort_at);
    bus.state_in  = TRIG;
    bus.hcount_in = 11'd15;
    bus.vcount_in = 10'd7;
    for (int i = 0; i <= 12; i++) begin
      tick();
      if (abort_at >= 0 && i == abort_at) begin
        chk($sformatf("abort_busy_%0d", i), 32'(bus.busy_out), 32'd0);
        chk($sformatf("abort_fin_%0d", i), 32'(bus.finished_out), 32'd0);
        chk($sformatf("abort_phase_%0d", i), 32'(bus.phase_out), 32'd0);
        tick();
        chk($sformatf("abort_fin_next_%0d", i), 32'(bus.finished_out), 32'd0);
        chk($sformatf("abort_pix_next_%0d", i), 32'(bus.pixel_out), 32'h000);
        break;
      end
      if (i < 12) begin
        chk($sformatf("run_busy_%0d", i), 32'(bus.busy_out), 32'd1);
        chk($sformatf("run_phase_%0d", i), 32'(bus.phase_out), 32'(i / 4));
        chk($sformatf("run_fin_%0d", i), 32'(bus.finished_out), 32'd0);
      end else begin
        chk("end_busy", 32'(bus.busy_out), 32'd0);
        chk("end_fin", 32'(bus.finished_out), 32'd1);
        chk("end_phase", 32'(bus.phase_out), 32'd2);
      end
      case (i)
        1:  chk("pix_phase0", 32'(bus.pixel_out), 32'h0F0);
        5:  chk("pix_phase1_in", 32'(bus.pixel_out), 32'hF00);
        6:  chk("pix_phase1_out", 32'(bus.pixel_out), 32'h000);
        9:  chk("pix_phase2", 32'(bus.pixel_out), 32'h0F0);
        12: chk("pix_last_run", 32'(bus.pixel_out), 32'h0F0);
        default: ;
      endcase
      if (i == 5) bus.hcount_in = 11'd20;
      if (i == 6) bus.hcount_in = 11'd15;
      if (abort_at >= 0 && i == abort_at - 1) bus.state_in = 4'h3;
    end
  endtask

  initial begin
    rst           = 1'b0;
    bus.state_in  = TRIG;
    bus.hcount_in = 11'd15;
    bus.vcount_in = 10'd7;
    tick();
    tick();
    chk("rst_busy", 32'(bus.busy_out), 32'd0);
    chk("rst_fin", 32'(bus.finished_out), 32'd0);
    chk("rst_phase", 32'(bus.phase_out), 32'd0);
    chk("rst_pix", 32'(bus.pixel_out), 32'h000);

    // Release with state_in already at the trigger code: nothing may start.
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("post_rst_busy_%0d", i), 32'(bus.busy_out), 32'd0);
    end

    bus.state_in = 4'h0;
    tick();
    run_seq(-1);

    // Held in DONE: no retrigger, last frame persists.
    for (int i = 0; i < 50; i++) begin
      tick();
      chk($sformatf("done_busy_%0d", i), 32'(bus.busy_out), 32'd0);
      chk($sformatf("done_fin_%0d", i), 32'(bus.finished_out), 32'd0);
    end
    chk("done_phase", 32'(bus.phase_out), 32'd2);
    chk("done_pix", 32'(bus.pixel_out), 32'h0F0);

    bus.state_in = 4'h0;
    tick();
    chk("exit_busy", 32'(bus.busy_out), 32'd0);
    chk("exit_phase", 32'(bus.phase_out), 32'd0);
    tick();
    chk("exit_pix", 32'(bus.pixel_out), 32'h000);

    run_seq(-1);
    bus.state_in = 4'h0;
    tick();
    tick();

    run_seq(6);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("after_abort6_fin_%0d", i), 32'(bus.finished_out), 32'd0);
      chk($sformatf("after_abort6_busy_%0d", i), 32'(bus.busy_out), 32'd0);
    end

    run_seq(12);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("after_abort12_fin_%0d", i), 32'(bus.finished_out), 32'd0);
    end

    // Reset in the middle of a run.
    bus.state_in = 4'h0;
    tick();
    bus.state_in = TRIG;
    for (int i = 0; i < 5; i++) tick();
    chk("pre_rst_busy", 32'(bus.busy_out), 32'd1);
    chk("pre_rst_phase", 32'(bus.phase_out), 32'd1);
    rst = 1'b0;
    #1;
    chk("midrst_busy", 32'(bus.busy_out), 32'd0);
    chk("midrst_fin", 32'(bus.finished_out), 32'd0);
    chk("midrst_phase", 32'(bus.phase_out), 32'd0);
    chk("midrst_pix", 32'(bus.pixel_out), 32'h000);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk($sformatf("midrst_hold_busy_%0d", i), 32'(bus.busy_out), 32'd0);
      chk($sformatf("midrst_hold_fin_%0d", i), 32'(bus.finished_out), 32'd0);
    end

    bus.state_in = 4'h0;
    tick();
    run_seq(-1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
